// File: rtl/tpu_ctrl_pkg.sv
// Shared types and defaults for the TPU sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package tpu_ctrl_pkg;

    // PE array edge and global-buffer index width
    localparam int DEF_ARRAY_SIZE = 4;
    localparam int DEF_IDX_W      = 8;
    // m/n/k input width; dims are limited to 0..15
    localparam int DIM_W          = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/tpu_tile_cnt.sv
// Nested step / nt / mt counter with wrap flags for the tile walk.
// Latency: counts update on the edge after an enable; flags are combinational from the counts.
// Backpressure: none; it advances only when the sequencer enables it.
module tpu_tile_cnt #(
    parameter int STEP_W = 4,
    parameter int TILE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              step_en,
    input  logic              tile_adv,
    input  logic [STEP_W-1:0] step_lim,
    input  logic [TILE_W-1:0] nt_last,
    input  logic [TILE_W-1:0] mt_last,
    output logic [TILE_W-1:0] nt,
    output logic [TILE_W-1:0] mt,
    output logic              step_wrap,
    output logic              tile_wrap
);

    logic [STEP_W-1:0] step;

    assign step_wrap = (step == step_lim);
    assign tile_wrap = (nt == nt_last) && (mt == mt_last);

    // Step counter self-wraps at its limit; nt is the inner tile loop, mt the outer
    always_ff @(posedge clk) begin
        if (rst || init) begin
            step <= '0;
            nt   <= '0;
            mt   <= '0;
        end else begin
            if (step_en) begin
                step <= step_wrap ? '0 : step + STEP_W'(1);
            end
            if (tile_adv) begin
                if (nt == nt_last) begin
                    nt <= '0;
                    mt <= mt + TILE_W'(1);
                end else begin
                    nt <= nt + TILE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tpu_ctrl.sv
// TPU sequencer: tiles an m x k by k x n matmul into ARRAY_SIZE^2 output tiles.
// Latency: 1+K+(2*ARRAY_SIZE-1)+ARRAY_SIZE cycles per tile, tiles back to back.
// Backpressure: none; start is taken only in IDLE/DONE and ignored while busy.
module tpu_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int IDX_W      = DEF_IDX_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DIM_W-1:0]              m,
    input  logic [DIM_W-1:0]              n,
    input  logic [DIM_W-1:0]              k,
    output logic [IDX_W-1:0]              index_a,
    output logic [IDX_W-1:0]              index_b,
    output logic [IDX_W-1:0]              index_out,
    output logic                          wr_en_out,
    output logic                          pe_clear,
    output logic                          pe_valid,
    output logic [$clog2(ARRAY_SIZE)-1:0] out_sel,
    output logic                          busy,
    output logic                          done
);

    localparam int SEL_W     = $clog2(ARRAY_SIZE);
    localparam int FLUSH_CYC = 2 * ARRAY_SIZE - 1;
    // step must cover the longest phase: FEED (up to 15) or FLUSH
    localparam int STEP_W    = (DIM_W > $clog2(FLUSH_CYC + 1)) ? DIM_W : $clog2(FLUSH_CYC + 1);
    localparam int TILE_W    = DIM_W;

    state_t             state;
    logic [DIM_W-1:0]   m_l;
    logic [DIM_W-1:0]   k_l;
    logic [TILE_W-1:0]  nt_last;
    logic [TILE_W-1:0]  mt_last;
    logic [IDX_W-1:0]   row;

    logic               start_acc;
    logic               dims_zero;
    logic               step_en;
    logic               tile_adv;
    logic [STEP_W-1:0]  step_lim;
    logic [TILE_W-1:0]  nt;
    logic [TILE_W-1:0]  mt;
    logic               step_wrap;
    logic               tile_wrap;

    logic [IDX_W-1:0]   a_base;
    logic [IDX_W-1:0]   b_base;
    logic [IDX_W-1:0]   out_base;
    logic [IDX_W-1:0]   row_base;
    logic [IDX_W-1:0]   row_next;
    logic [IDX_W-1:0]   m_ext;

    assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));
    assign dims_zero = (m == '0) || (n == '0) || (k == '0);
    assign step_en   = (state == S_FEED) || (state == S_FLUSH) || (state == S_WRITE);
    assign tile_adv  = (state == S_WRITE) && step_wrap;

    // Per-tile base addresses from the current tile coordinates
    assign a_base   = IDX_W'(mt) * IDX_W'(k_l);
    assign b_base   = IDX_W'(nt) * IDX_W'(k_l);
    assign out_base = (IDX_W'(mt) * (IDX_W'(nt_last) + IDX_W'(1)) + IDX_W'(nt)) * IDX_W'(ARRAY_SIZE);
    assign row_base = IDX_W'(mt) * IDX_W'(ARRAY_SIZE);
    assign row_next = row + IDX_W'(1);
    assign m_ext    = IDX_W'(m_l);

    // Last step index of the phase currently running
    always_comb begin
        step_lim = '0;
        case (state)
            S_FEED:  step_lim = STEP_W'(k_l - DIM_W'(1));
            S_FLUSH: step_lim = STEP_W'(FLUSH_CYC - 1);
            S_WRITE: step_lim = STEP_W'(ARRAY_SIZE - 1);
            default: step_lim = '0;
        endcase
    end

    tpu_tile_cnt #(
        .STEP_W (STEP_W),
        .TILE_W (TILE_W)
    ) u_tile_cnt (
        .clk       (clk),
        .rst       (rst),
        .init      (start_acc),
        .step_en   (step_en),
        .tile_adv  (tile_adv),
        .step_lim  (step_lim),
        .nt_last   (nt_last),
        .mt_last   (mt_last),
        .nt        (nt),
        .mt        (mt),
        .step_wrap (step_wrap),
        .tile_wrap (tile_wrap)
    );

    // Sequencer FSM; every output is loaded with the value for the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            m_l       <= '0;
            k_l       <= '0;
            nt_last   <= '0;
            mt_last   <= '0;
            row       <= '0;
            index_a   <= '0;
            index_b   <= '0;
            index_out <= '0;
            wr_en_out <= 1'b0;
            pe_clear  <= 1'b0;
            pe_valid  <= 1'b0;
            out_sel   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pe_clear  <= 1'b0;
            wr_en_out <= 1'b0;
            // buffer read data lags the index by one cycle
            pe_valid  <= (state == S_FEED);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        m_l     <= m;
                        k_l     <= k;
                        nt_last <= TILE_W'((n - DIM_W'(1)) / DIM_W'(ARRAY_SIZE));
                        mt_last <= TILE_W'((m - DIM_W'(1)) / DIM_W'(ARRAY_SIZE));
                        if (dims_zero) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_CLEAR;
                            pe_clear <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                        end
                    end
                end
                S_CLEAR: begin
                    state   <= S_FEED;
                    index_a <= a_base;
                    index_b <= b_base;
                end
                S_FEED: begin
                    if (step_wrap) begin
                        state <= S_FLUSH;
                    end else begin
                        index_a <= index_a + IDX_W'(1);
                        index_b <= index_b + IDX_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (step_wrap) begin
                        state     <= S_WRITE;
                        index_out <= out_base;
                        out_sel   <= '0;
                        row       <= row_base;
                        wr_en_out <= (row_base < m_ext);
                    end
                end
                S_WRITE: begin
                    if (!step_wrap) begin
                        index_out <= index_out + IDX_W'(1);
                        out_sel   <= out_sel + SEL_W'(1);
                        row       <= row_next;
                        wr_en_out <= (row_next < m_ext);
                    end else begin
                        out_sel <= '0;
                        if (tile_wrap) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_CLEAR;
                            pe_clear <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_ctrl.sv
// Directed bench for the TPU sequencer against hand-derived cycle traces.
// Latency: cycle 1 is the first cycle after the edge that accepts start.
// Backpressure: none; start pulses are driven for exactly one edge.
module tb_tpu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] m, n, k;
    logic [7:0] index_a, index_b, index_out;
    logic       wr_en_out, pe_clear, pe_valid, busy, done;
    logic [1:0] out_sel;

    int errs   = 0;
    int checks = 0;

    wire [4:0] flg = {pe_clear, pe_valid, wr_en_out, busy, done};

    tpu_ctrl #(.ARRAY_SIZE(4), .IDX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .m         (m),
        .n         (n),
        .k         (k),
        .index_a   (index_a),
        .index_b   (index_b),
        .index_out (index_out),
        .wr_en_out (wr_en_out),
        .pe_clear  (pe_clear),
        .pe_valid  (pe_valid),
        .out_sel   (out_sel),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] mm, input logic [3:0] nn, input logic [3:0] kk);
        m = mm; n = nn; k = kk;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // m=n=k=4 single tile; optional ignored start pulses with a changed m
    task automatic run_s1(input bit repulse, input string tg);
        logic [4:0] ef;
        int         e;
        launch(4'd4, 4'd4, 4'd4);
        for (int c = 1; c <= 18; c++) begin
            ef = {c == 1, (c >= 3) && (c <= 6), (c >= 13) && (c <= 16), c <= 16, c >= 17};
            chk($sformatf("%s flags c%0d", tg, c), 32'(flg), 32'(ef));
            if (c >= 2 && c <= 12) begin
                e = (c - 2 > 3) ? 3 : c - 2;
                chk($sformatf("%s index_a c%0d", tg, c), 32'(index_a), 32'(e));
                chk($sformatf("%s index_b c%0d", tg, c), 32'(index_b), 32'(e));
            end
            if (c >= 13 && c <= 16) begin
                chk($sformatf("%s index_out c%0d", tg, c), 32'(index_out), 32'(c - 13));
                chk($sformatf("%s out_sel c%0d", tg, c), 32'(out_sel), 32'(c - 13));
            end
            if (repulse && (c == 3 || c == 10)) begin
                m = 4'd8;
                start = 1'b1;
                step();
                start = 1'b0;
            end else begin
                step();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ef4;
        int         seen;
        int         writes;
        int         maxidx;
        int         cyc;

        rst = 1'b1; start = 1'b0; m = '0; n = '0; k = '0;
        repeat (3) step();
        chk("reset outputs", 32'({index_a, index_b, index_out, out_sel, flg}), 32'd0);
        rst = 1'b0;
        step();

        // single tile
        run_s1(1'b0, "s1");

        // zero dimension: straight to DONE, no activity
        launch(4'd0, 4'd4, 4'd4);
        chk("s3 flags c1", 32'(flg), 32'b00001);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (wr_en_out || pe_clear || busy) seen++;
            step();
        end
        chk("s3 no activity", 32'(seen), 32'd0);
        chk("s3 done held", 32'(done), 32'd1);

        // m=5,n=3,k=2: two tiles, second tile writes only row 4
        launch(4'd5, 4'd3, 4'd2);
        for (int c = 1; c <= 30; c++) begin
            ef4 = {(c == 1) || (c == 15),
                   ((c >= 11) && (c <= 14)) || (c == 25),
                   c <= 28, c >= 29};
            chk($sformatf("s2 flags c%0d", c), 32'({pe_clear, wr_en_out, busy, done}), 32'(ef4));
            if (c >= 11 && c <= 14)
                chk($sformatf("s2 index_out c%0d", c), 32'(index_out), 32'(c - 11));
            if (c == 25)
                chk("s2 index_out c25", 32'(index_out), 32'd4);
            if (c == 2 || c == 3) begin
                chk($sformatf("s2 t0 index_a c%0d", c), 32'(index_a), 32'(c - 2));
                chk($sformatf("s2 t0 index_b c%0d", c), 32'(index_b), 32'(c - 2));
            end
            if (c == 16 || c == 17) begin
                chk($sformatf("s2 t1 index_a c%0d", c), 32'(index_a), 32'(c - 14));
                chk($sformatf("s2 t1 index_b c%0d", c), 32'(index_b), 32'(c - 16));
            end
            step();
        end

        // reset in the second FEED cycle aborts the run
        launch(4'd4, 4'd4, 4'd4);
        step();
        step();
        rst = 1'b1;
        step();
        chk("s4 outputs after rst", 32'({index_a, index_b, index_out, out_sel, flg}), 32'd0);
        rst = 1'b0;
        step();
        run_s1(1'b0, "s4");

        // start pulses while busy are ignored
        run_s1(1'b1, "s5");

        // m=n=k=15: 16 tiles of 27 cycles, 60 enabled writes
        launch(4'd15, 4'd15, 4'd15);
        writes = 0;
        maxidx = 0;
        cyc    = 1;
        while (!done && cyc < 1000) begin
            if (wr_en_out) writes++;
            if (busy && int'(index_out) > maxidx) maxidx = int'(index_out);
            step();
            cyc++;
        end
        chk("s6 done cycle", 32'(cyc), 32'd433);
        chk("s6 write count", 32'(writes), 32'd60);
        chk("s6 max index_out", 32'(maxidx), 32'd63);
        repeat (5) step();
        chk("s6 done held", 32'({busy, done}), 32'b01);

        // next start clears done and runs normally
        run_s1(1'b0, "s6b");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
